// File: rtl/cpu_step_clock_ctrl.sv
// CPU clock/step generator with debounced single-step button, cycle counter
// and paged 16-bit view of a wide CPU data word for the 7-seg driver.
module cpu_step_clock_ctrl #(
  parameter int unsigned DIV_SLOW   = 75_000_000,
  parameter int unsigned DIV_FAST   = 1_000_000,
  parameter int unsigned DEBOUNCE   = 1_000_000,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SCROLL_DIV = 100_000_000,
  localparam int unsigned PAGES     = DATA_W / 16,
  localparam int unsigned PAGE_W    = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic              CLK,
  input  logic              res,
  input  logic [1:0]        mode,
  input  logic              stepBtn,
  input  logic              autoScroll,
  input  logic [PAGE_W-1:0] pageSel,
  input  logic [DATA_W-1:0] cpuData,
  output logic              slowClk,
  output logic              stepTick,
  output logic [31:0]       cycleCount,
  output logic [PAGE_W-1:0] pageIdx,
  output logic [15:0]       dispData
);

  localparam int unsigned SLOTS = 1 << PAGE_W;

  typedef enum logic [1:0] {
    M_PAUSE = 2'b00,
    M_RUN   = 2'b01,
    M_STEP  = 2'b10,
    M_FAST  = 2'b11
  } mode_e;

  mode_e       mode_in;
  mode_e       mode_q;
  logic [31:0] div_cnt;
  logic [31:0] div_nxt;
  logic        slow_nxt;
  logic        rise;

  logic        sync1;
  logic        sync2;
  logic        deb_lvl;
  logic        deb_prev;
  logic [31:0] deb_cnt;

  logic              auto_q;
  logic [31:0]       scroll_cnt;
  logic [31:0]       scroll_nxt;
  logic [PAGE_W-1:0] page_nxt;
  logic [31:0]       sel_wide;
  logic [15:0]       words [SLOTS];

  assign mode_in = mode_e'(mode);
  assign rise    = slow_nxt & ~slowClk;

  // In STEP, slowClk can only be high while a step is in progress, so it
  // doubles as the step-active flag and div_cnt times the high phase.
  always_comb begin
    div_nxt  = div_cnt;
    slow_nxt = slowClk;
    if (mode_in != mode_q) begin
      div_nxt = '0;
      if (mode_in == M_STEP) slow_nxt = 1'b0;
    end else begin
      case (mode_in)
        M_RUN: begin
          if (div_cnt == DIV_SLOW - 1) begin
            div_nxt  = '0;
            slow_nxt = ~slowClk;
          end else begin
            div_nxt = div_cnt + 32'd1;
          end
        end
        M_FAST: begin
          if (div_cnt == DIV_FAST - 1) begin
            div_nxt  = '0;
            slow_nxt = ~slowClk;
          end else begin
            div_nxt = div_cnt + 32'd1;
          end
        end
        M_STEP: begin
          if (slowClk) begin
            if (div_cnt == DIV_FAST - 1) begin
              div_nxt  = '0;
              slow_nxt = 1'b0;
            end else begin
              div_nxt = div_cnt + 32'd1;
            end
          end else if (deb_lvl && !deb_prev) begin
            div_nxt  = '0;
            slow_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (res) begin
      mode_q     <= M_PAUSE;
      div_cnt    <= '0;
      slowClk    <= 1'b0;
      stepTick   <= 1'b0;
      cycleCount <= '0;
    end else begin
      mode_q     <= mode_in;
      div_cnt    <= div_nxt;
      slowClk    <= slow_nxt;
      stepTick   <= rise;
      cycleCount <= cycleCount + {31'b0, rise};
    end
  end

  // Level is accepted only after DEBOUNCE consecutive samples differing from it.
  always_ff @(posedge CLK) begin
    if (res) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      deb_lvl  <= 1'b0;
      deb_prev <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      sync1    <= stepBtn;
      sync2    <= sync1;
      deb_prev <= deb_lvl;
      if (sync2 != deb_lvl) begin
        if (deb_cnt == DEBOUNCE - 1) begin
          deb_lvl <= sync2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 32'd1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < SLOTS; i++) words[i] = '0;
    for (int unsigned i = 0; i < PAGES; i++) words[i] = cpuData[i*16 +: 16];
  end

  always_comb begin
    scroll_nxt = scroll_cnt;
    page_nxt   = pageIdx;
    sel_wide   = '0;
    sel_wide[PAGE_W-1:0] = pageSel;
    if (autoScroll) begin
      if (!auto_q) begin
        scroll_nxt = '0;
      end else if (scroll_cnt == SCROLL_DIV - 1) begin
        scroll_nxt = '0;
        page_nxt   = (pageIdx == PAGE_W'(PAGES - 1)) ? '0 : pageIdx + PAGE_W'(1);
      end else begin
        scroll_nxt = scroll_cnt + 32'd1;
      end
    end else begin
      scroll_nxt = '0;
      page_nxt   = (sel_wide >= PAGES) ? PAGE_W'(PAGES - 1) : pageSel;
    end
  end

  always_ff @(posedge CLK) begin
    if (res) begin
      auto_q     <= 1'b0;
      scroll_cnt <= '0;
      pageIdx    <= '0;
      dispData   <= '0;
    end else begin
      auto_q     <= autoScroll;
      scroll_cnt <= scroll_nxt;
      pageIdx    <= page_nxt;
      dispData   <= words[page_nxt];
    end
  end

endmodule
